// File: rtl/ps2_receiver_if.sv
// Receive-side bundle from the PS/2 receiver to the display stage.
// master: driven by ps2_receiver; slave: consumed by the display/status logic.
interface ps2_receiver_if;
  logic [7:0] ps2_byte;
  logic       ps2_recflag;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       busy;

  modport master (
    output ps2_byte,
    output ps2_recflag,
    output frame_err,
    output err_cnt,
    output busy
  );

  modport slave (
    input ps2_byte,
    input ps2_recflag,
    input frame_err,
    input err_cnt,
    input busy
  );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver.
// Synchronizes the raw PS/2 pins, detects ps2_clk falling edges, assembles
// 11-bit frames (start, 8 data LSB first, odd parity, stop) and presents
// accepted bytes with a one-cycle strobe. Bad or stalled frames raise a
// one-cycle error strobe and bump a saturating error counter.
module ps2_receiver #(
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_receiver_if.master    rx
);

  localparam int unsigned IW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC - 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t        state;
  logic          clk_s1, clk_s2, clk_s3;
  logic          data_s1, data_s2;
  logic          fall_r;
  logic          data_r;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_r;
  logic [IW-1:0] idle_cnt;
  logic [7:0]    byte_r;
  logic          recflag_r;
  logic          ferr_r;
  logic [7:0]    err_cnt_r;

  // Two-flop synchronizers on both pins plus a third ps2_clk stage for edge detect; idle bus is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Register the falling-edge event and the data bit sampled with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fall_r <= 1'b0;
      data_r <= 1'b1;
    end else begin
      fall_r <= clk_s3 & ~clk_s2;
      if (clk_s3 & ~clk_s2) begin
        data_r <= data_s2;
      end
    end
  end

  // Frame FSM with registered byte, strobes, error counter and stall timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      parity_r  <= 1'b0;
      idle_cnt  <= '0;
      byte_r    <= '0;
      recflag_r <= 1'b0;
      ferr_r    <= 1'b0;
      err_cnt_r <= '0;
    end else begin
      recflag_r <= 1'b0;
      ferr_r    <= 1'b0;
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (fall_r && !data_r) begin
            state   <= RECV;
            bit_cnt <= '0;
          end
        end
        RECV: begin
          if (fall_r) begin
            idle_cnt <= '0;
            if (bit_cnt < 4'd8) begin
              shift   <= {data_r, shift[7:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd8) begin
              parity_r <= data_r;
              bit_cnt  <= bit_cnt + 4'd1;
            end else begin
              state   <= IDLE;
              bit_cnt <= '0;
              if ((^{shift, parity_r}) && data_r) begin
                byte_r    <= shift;
                recflag_r <= 1'b1;
              end else begin
                ferr_r <= 1'b1;
                if (err_cnt_r != 8'hFF) begin
                  err_cnt_r <= err_cnt_r + 8'd1;
                end
              end
            end
          end else if (idle_cnt == IDLE_MAX) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            ferr_r   <= 1'b1;
            if (err_cnt_r != 8'hFF) begin
              err_cnt_r <= err_cnt_r + 8'd1;
            end
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign rx.ps2_byte    = byte_r;
  assign rx.ps2_recflag = recflag_r;
  assign rx.frame_err   = ferr_r;
  assign rx.err_cnt     = err_cnt_r;
  assign rx.busy        = (state == RECV);

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: valid, parity-bad, stop-bad, stalled,
// back-to-back, mid-frame reset and error-counter saturation frames.
module tb_ps2_receiver;

  localparam int unsigned TO = 200;

  logic clk;
  logic rst;
  logic ps2_clk;
  logic ps2_data;

  ps2_receiver_if rx ();

  ps2_receiver #(.TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (rx.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int rec_cnt     = 0;
  int ferr_cnt    = 0;
  int overlap_cnt = 0;
  logic [7:0] seen [0:15];
  int last_lat;

  // Strobe monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (rx.ps2_recflag) begin
      seen[rec_cnt % 16] = rx.ps2_byte;
      rec_cnt = rec_cnt + 1;
    end
    if (rx.frame_err) ferr_cnt = ferr_cnt + 1;
    if (rx.ps2_recflag && rx.frame_err) overlap_cnt = overlap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One PS/2 bit: data set while clk high, then clk low for 6 rising edges.
  // The rising edge count to the first strobe after the low edge goes to last_lat.
  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (3) @(negedge clk);
    ps2_clk  = 1'b0;
    last_lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (last_lat == 0 && (rx.ps2_recflag || rx.frame_err)) last_lat = k;
    end
    @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of {stop, parity, data, start=0}.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int unsigned nbits);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) send_bit(f[i]);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  int r0, e0;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_byte",    rx.ps2_byte,    32'h00);
    check("rst_recflag", rx.ps2_recflag, 32'h0);
    check("rst_ferr",    rx.frame_err,   32'h0);
    check("rst_errcnt",  rx.err_cnt,     32'h0);
    check("rst_busy",    rx.busy,        32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Valid 0x1C, parity 0
    r0 = rec_cnt; e0 = ferr_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check("v1c_latency", last_lat,          32'd4);
    check("v1c_rec",     rec_cnt - r0,      32'd1);
    check("v1c_byte",    rx.ps2_byte,       32'h1C);
    check("v1c_ferr",    ferr_cnt - e0,     32'd0);
    check("v1c_errcnt",  rx.err_cnt,        32'd0);
    check("v1c_busy",    rx.busy,           32'd0);

    // Valid 0x5A (four ones, parity 1)
    send_frame(8'h5A, 1'b1, 1'b1, 11);
    check("v5a_byte",    rx.ps2_byte,       32'h5A);

    // 0x1C with parity 1: rejected, byte holds 0x5A
    r0 = rec_cnt; e0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    check("par_ferr",    ferr_cnt - e0,     32'd1);
    check("par_rec",     rec_cnt - r0,      32'd0);
    check("par_errcnt",  rx.err_cnt,        32'd1);
    check("par_byte",    rx.ps2_byte,       32'h5A);

    // Stop bit 0
    r0 = rec_cnt; e0 = ferr_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    check("stop_ferr",   ferr_cnt - e0,     32'd1);
    check("stop_rec",    rec_cnt - r0,      32'd0);
    check("stop_errcnt", rx.err_cnt,        32'd2);
    check("stop_busy",   rx.busy,           32'd0);

    // Stall after 5 bits (start + 4 data), then timeout
    r0 = rec_cnt; e0 = ferr_cnt;
    send_frame(8'hF0, 1'b1, 1'b1, 5);
    check("to_busy_mid", rx.busy,           32'd1);
    repeat (TO + 20) @(negedge clk);
    check("to_ferr",     ferr_cnt - e0,     32'd1);
    check("to_busy",     rx.busy,           32'd0);
    check("to_errcnt",   rx.err_cnt,        32'd3);
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    check("to_next",     rx.ps2_byte,       32'hF0);
    check("to_rec",      rec_cnt - r0,      32'd1);

    // Back-to-back 0xF0 then 0x1C
    r0 = rec_cnt;
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check("b2b_rec",     rec_cnt - r0,      32'd2);
    check("b2b_first",   seen[r0 % 16],     32'hF0);
    check("b2b_second",  seen[(r0 + 1) % 16], 32'h1C);

    // Reset during bit 4 of a 0x1C frame
    r0 = rec_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    @(negedge clk);
    ps2_data = 1'b1;
    ps2_clk  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mrst_byte",   rx.ps2_byte,       32'h00);
    check("mrst_rec",    rx.ps2_recflag,    32'h0);
    check("mrst_ferr",   rx.frame_err,      32'h0);
    check("mrst_errcnt", rx.err_cnt,        32'h0);
    check("mrst_busy",   rx.busy,           32'h0);
    ps2_clk = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("mrst_nostb",  rec_cnt - r0,      32'd0);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check("mrst_next",   rx.ps2_byte,       32'h1C);

    // 260 parity-bad frames saturate err_cnt at 255
    for (int n = 0; n < 260; n++) begin
      send_frame(8'h00, 1'b0, 1'b1, 11);
      if (n == 253) check("sat_254", rx.err_cnt, 32'd254);
    end
    check("sat_errcnt",  rx.err_cnt,        32'd255);
    check("sat_byte",    rx.ps2_byte,       32'h1C);
    check("no_overlap",  overlap_cnt,       32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 20000, the clk cycles without a ps2_clk falling edge before an in-progress frame is aborted.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port ps2_clk, input, 1, raw PS/2 clock pin, asynchronous to clk.
REQ-005 SHALL have port ps2_data, input, 1, raw PS/2 data pin, asynchronous to clk.
REQ-006 SHALL have port ps2_byte, output, 8, last correctly received scan-code byte, feeding the display stage's data input.
REQ-007 SHALL have port ps2_recflag, output, 1, one-cycle strobe marking that ps2_byte was just updated, feeding the display stage's receive flag.
REQ-008 SHALL have port frame_err, output, 1, one-cycle strobe on any rejected or aborted frame.
REQ-009 SHALL have port err_cnt, output, 8, saturating count of rejected or aborted frames.
REQ-010 SHALL have port busy, output, 1, high while a frame is in progress (state RECV).

Function
REQ-011 SHALL pass ps2_clk and ps2_data through two-flop synchronizers, then a third ps2_clk register; fall = third register high and second register low.
REQ-012 SHALL sample synchronized ps2_data only in cycles where fall is true.
REQ-013 SHALL implement states IDLE and RECV; frame format is start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-014 IDLE: on fall with data 0, go to RECV with bit_cnt=0; on fall with data 1, stay IDLE with no strobe and no count change.
REQ-015 RECV: on each fall, bit_cnt 0..7 shifts a data bit, 8 captures parity, 9 captures stop and returns to IDLE.
REQ-016 A frame SHALL be accepted only if XOR(data[7:0], parity)=1 and stop=1.
REQ-017 On an accepted frame, ps2_byte SHALL load the data and ps2_recflag SHALL be high for exactly one cycle, the same cycle ps2_byte changes.
REQ-018 Latency: ps2_recflag rises at the 4th rising clk edge after the stop-bit falling level is first present at the ps2_clk pin (2 sync, 1 edge, 1 output register).
REQ-019 On a rejected frame, ps2_byte SHALL hold, ps2_recflag SHALL stay 0, frame_err SHALL pulse for one cycle, and err_cnt SHALL increment.
REQ-020 In RECV, an idle counter SHALL clear on every fall and increment otherwise; when it reaches TIMEOUT_CYC-1, the FSM SHALL return to IDLE, pulse frame_err and increment err_cnt.
REQ-021 err_cnt SHALL saturate at 255 and never wrap.
REQ-022 ps2_recflag and frame_err SHALL never be high in the same cycle.
REQ-023 Back-to-back frames with no idle gap beyond the stop bit SHALL each be received, one strobe per frame.
REQ-024 busy SHALL equal (state==RECV); it SHALL drop in the same cycle as the final strobe.

Reset
REQ-025 While rst=0, SHALL force: state IDLE, bit_cnt 0, shift register 0, idle counter 0, synchronizer flops 1 (bus idle).
REQ-026 While rst=0, SHALL force outputs: ps2_byte 0x00, ps2_recflag 0, frame_err 0, err_cnt 0, busy 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no strobe; the first full frame after release SHALL be received normally.

Verification
REQ-028 Valid 0x1C frame (bits 0,0,0,1,1,1,0,0,0,0,1; parity 0) -> one ps2_recflag pulse, ps2_byte=0x1C, err_cnt=0.
REQ-029 0x1C with parity 1 -> frame_err pulse, err_cnt=1, ps2_byte still equals the previous value, no ps2_recflag.
REQ-030 Valid data and parity with stop bit 0 -> frame_err pulse, err_cnt increments, busy returns to 0.
REQ-031 Frame stopped after 5 bits, clock held high for TIMEOUT_CYC cycles -> frame_err pulse and busy=0; the next valid 0xF0 frame gives ps2_byte=0xF0.
REQ-032 Back-to-back 0xF0 then 0x1C -> two ps2_recflag pulses, ps2_byte 0xF0 then 0x1C; 260 bad frames -> err_cnt=255.
REQ-033 rst=0 pulsed during bit 4 of a frame -> all outputs at reset values, no strobe; the following valid 0x1C frame gives ps2_byte=0x1C.
